fma_issue_scheduler: RTL and testbench
======================================

# fma_issue_scheduler

Shares one 5-stage pipelined FP32 FMA datapath (result = a*b+c) among NUM_REQ requesters. Round-robin arbitration picks one operand triple per cycle, registers it into the datapath, and carries the requester ID alongside the datapath in a valid/ID shift register. Results land in a credit-protected result FIFO, so the datapath itself never stalls. The block sits between the requesters and the FMA stage chain and is the datapath's only sequencer.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8
- LAT, 5: datapath latency in cycles from fma_in_valid to a valid fma_result
- FIFO_DEPTH, 8: result FIFO entries; power of two, ≥2

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a, req_b, req_c  in  NUM_REQ×32  per-requester FP32 operands
- fma_a, fma_b, fma_c  out  32 each  registered operands to the datapath
- fma_in_valid  out  1  operand registers hold a live operation
- fma_result  in  32  datapath output; sampled only when the ID pipe tail is valid
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer pop
- res_data  out  32  FIFO head result
- res_id  out  IDW  FIFO head requester index; IDW = max(1, $clog2(NUM_REQ))
- stat_issued, stat_blocked  out  32 each  present only with FMA_SCHED_STATS_EN

## Operation
- Outstanding counter `outst`, width $clog2(FIFO_DEPTH+1), counts operations that have been accepted and not yet popped.
  - Increment on accept.
  - Decrement on pop (res_valid & res_ready).
  - If both happen in the same cycle, `outst` is unchanged.
- Issue is allowed when outst < FIFO_DEPTH. This guarantees the FIFO never overflows and makes a full-FIFO write impossible by construction. Assert this in the bench.
- Arbiter:
  - Round-robin over req_valid, starting at priority pointer `ptr`.
  - Grant = the first valid index at or after `ptr`, modulo NUM_REQ.
  - req_ready[i] = allowed & grant[i]; this is a combinational path from req_valid.
  - Accept = req_valid[i] & req_ready[i].
  - On accept, ptr ← i+1 mod NUM_REQ. Without an accept, ptr holds.
- On accept, the operand registers load the granted triple and fma_in_valid = 1 for the next cycle. Without an accept, fma_in_valid = 0 and the operand registers hold their old values.
- ID pipe: LAT entries of {valid, id}. Entry 0 loads {fma_in_valid, id of the operation in the operand registers}. Entries shift every cycle with no stall.
- When the tail entry is valid, {fma_result, tail id} is written into the FIFO at that edge.
- FIFO: show-ahead. res_data and res_id are driven from the head entry.
  - A write to an empty FIFO with a simultaneous pop of nothing makes res_valid = 1 after that edge.
  - A simultaneous write and pop keeps the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - req_ready 0 while in reset.
  - fma_a, fma_b, fma_c = 0; fma_in_valid = 0.
  - ID pipe valids = 0; FIFO empty (res_valid = 0); res_data = 0; res_id = 0.
  - ptr = 0; outst = 0; stats = 0.
- Reset during operation discards all in-flight and buffered results. Any result arriving from the datapath after reset is ignored because the ID pipe valids are cleared.

## Timing
- Accept at edge k:
  - fma_in_valid high in cycle k→k+1.
  - fma_result valid in cycle k+LAT→k+LAT+1.
  - FIFO write at edge k+LAT+1.
  - res_valid high from edge k+LAT+1.
- Accept-to-res_valid latency = LAT+1 edges (6 at defaults).
- Sustained throughput is 1 op/cycle while res_ready stays high.
- With res_ready held low, exactly FIFO_DEPTH accepts occur, then req_ready stays 0. One pop re-enables issue in the cycle after the pop edge.

## Configuration
- FMA_SCHED_STATS_EN defined:
  - stat_issued counts accepts.
  - stat_blocked counts cycles with any req_valid high while outst == FIFO_DEPTH.
  - Both counters are 32-bit, wrap at 2^32, and clear on rst.
- Macro undefined: the stat ports and counter logic do not exist.

## Structure
- Package fma_sched_pkg holds:
  - FP32 width constant (32).
  - Default LAT constant (5).
  - typedef fma_op_t {a, b, c}.
  - typedef fma_res_t {data, id}.
- One sub-module: fma_sched_rr_arb (req vector, ptr, enable → one-hot grant, granted index).
- FIFO and ID pipe are inline.

## Test plan
- Single op: requester 2 sends a=0x40000000, b=0x40400000, c=0x3F800000 → after 6 edges, res_valid=1 with res_data=0x40E00000 and res_id=2.
- Round robin: all 4 req_valid held high, res_ready=1 → accepts in order 0,1,2,3,0,1 on consecutive edges; results return in the same order.
- Backpressure: res_ready=0, continuous requests → exactly 8 accepts, then req_ready=0; raise res_ready for one cycle → one pop, one new accept the next cycle.
- Simultaneous push/pop: FIFO holds 3 entries while the tail is valid and res_ready=1 → count stays 3, and data order is preserved across the pointer wrap.
- Reset mid-flight: assert rst with 4 in flight and 2 buffered → res_valid=0 immediately, no results appear afterwards, and ptr=0 (requester 0 is granted first).
- Stats (macro on): 10 accepts plus 3 cycles with the FIFO full and a request pending → stat_issued=10, stat_blocked=3.

Source files
------------

// File: rtl/fma_sched_pkg.sv
// rtl/fma_sched_pkg.sv - shared types and constants for the FMA issue scheduler
package fma_sched_pkg;

    localparam int FP_W    = 32;
    localparam int DEF_LAT = 5;
    localparam int MAX_IDW = 3;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic [FP_W-1:0] c;
    } fma_op_t;

    typedef struct packed {
        logic [FP_W-1:0]    data;
        logic [MAX_IDW-1:0] id;
    } fma_res_t;

    // Requester index width; a single requester bit is kept even for NUM_REQ=2
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fma_sched_rr_arb.sv
// rtl/fma_sched_rr_arb.sv - round-robin arbiter: first valid request at or after ptr
module fma_sched_rr_arb
    import fma_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               found
);

    // Scan from ptr upward with wrap; found/idx ignore enable, grant honours it
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            j = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                idx      = IDW'(j);
                grant[j] = enable;
            end
        end
    end

endmodule

// File: rtl/fma_issue_scheduler.sv
// rtl/fma_issue_scheduler.sv - shares one pipelined FMA among requesters; FMA_SCHED_STATS_EN adds stat counters
module fma_issue_scheduler
    import fma_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LAT        = DEF_LAT,
    parameter int FIFO_DEPTH = 8,
    localparam int IDW = id_width(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    input  logic [NUM_REQ*FP_W-1:0] req_c,
    output logic [FP_W-1:0]         fma_a,
    output logic [FP_W-1:0]         fma_b,
    output logic [FP_W-1:0]         fma_c,
    output logic                    fma_in_valid,
    input  logic [FP_W-1:0]         fma_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [FP_W-1:0]         res_data,
`ifdef FMA_SCHED_STATS_EN
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_blocked,
`endif
    output logic [IDW-1:0]          res_id
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [CW-1:0]   outst;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  op_id;
    logic            found;
    logic            allowed;
    logic            accept;
    logic            pop;
    logic            wr_en;
    fma_op_t         op_q;
    logic [LAT-1:0]  pipe_valid;
    logic [IDW-1:0]  pipe_id [LAT];
    logic [FP_W-1:0] mem_data [FIFO_DEPTH];
    logic [IDW-1:0]  mem_id [FIFO_DEPTH];

    // Credit check: every accepted op already owns a FIFO slot, so writes never see a full FIFO
    assign allowed = !rst && (outst < CW'(FIFO_DEPTH));
    assign accept  = found && allowed;
    assign pop     = res_valid && res_ready;
    assign wr_en   = pipe_valid[LAT-1];

    fma_sched_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .enable (allowed),
        .grant  (req_ready),
        .idx    (gnt_idx),
        .found  (found)
    );

    assign fma_a     = op_q.a;
    assign fma_b     = op_q.b;
    assign fma_c     = op_q.c;
    assign res_valid = (count != '0);
    assign res_data  = mem_data[rd_ptr];
    assign res_id    = mem_id[rd_ptr];

    // Priority pointer moves past the winner; outstanding credit tracks accept minus pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            outst <= '0;
        end else begin
            if (accept) begin
                ptr <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            case ({accept, pop})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
        end
    end

    // Operand registers hold their last value when nothing is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= '0;
            op_id        <= '0;
            fma_in_valid <= 1'b0;
        end else begin
            fma_in_valid <= accept;
            if (accept) begin
                op_q.a <= req_a[gnt_idx*FP_W +: FP_W];
                op_q.b <= req_b[gnt_idx*FP_W +: FP_W];
                op_q.c <= req_c[gnt_idx*FP_W +: FP_W];
                op_id  <= gnt_idx;
            end
        end
    end

    // Valid/ID pipe shadows the datapath stages; it never stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < LAT; i++) pipe_id[i] <= '0;
        end else begin
            pipe_valid[0] <= fma_in_valid;
            pipe_id[0]    <= op_id;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    // Show-ahead result FIFO; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_id[i]   <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_data[wr_ptr] <= fma_result;
                mem_id[wr_ptr]   <= pipe_id[LAT-1];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FMA_SCHED_STATS_EN
    // Issue and back-pressure statistics, free-running with 32-bit wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_blocked <= '0;
        end else begin
            if (accept) stat_issued <= stat_issued + 32'd1;
            if ((|req_valid) && (outst == CW'(FIFO_DEPTH))) stat_blocked <= stat_blocked + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fma_issue_scheduler.sv
// tb/tb_fma_issue_scheduler.sv - directed self-checking bench for fma_issue_scheduler
module tb_fma_issue_scheduler;
    import fma_sched_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int LAT        = 5;
    localparam int FIFO_DEPTH = 8;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] ready;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b, req_c;
    logic [31:0]  fma_a, fma_b, fma_c, fma_result, res_data;
    logic         fma_in_valid, res_valid, res_ready;
    logic [1:0]   res_id;
`ifdef FMA_SCHED_STATS_EN
    logic [31:0]  stat_issued, stat_blocked;
`endif

    int           checks = 0;
    int           errors = 0;
    fma_res_t     sbq[$];
    vec_t         tbl [13];
    int           rr_ptr, n_acc;
    logic [3:0]   exp_rdy;
    logic [31:0]  base;
    logic [31:0]  dp [LAT];

    fma_issue_scheduler #(.NUM_REQ(NUM_REQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_c        (req_c),
        .fma_a        (fma_a),
        .fma_b        (fma_b),
        .fma_c        (fma_c),
        .fma_in_valid (fma_in_valid),
        .fma_result   (fma_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
`ifdef FMA_SCHED_STATS_EN
        .stat_issued  (stat_issued),
        .stat_blocked (stat_blocked),
`endif
        .res_id       (res_id)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: known triple gives the true FMA, otherwise a tag-preserving xor
    function automatic logic [31:0] fma_model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (a == 32'h4000_0000 && b == 32'h4040_0000 && c == 32'h3F80_0000) return 32'h40E0_0000;
        return a ^ b ^ c;
    endfunction

    always @(posedge clk) begin
        dp[0] <= fma_model(fma_a, fma_b, fma_c);
        for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
    end
    assign fma_result = dp[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input int i);
        fma_res_t e;
        e.data = d;
        e.id   = 3'(i);
        sbq.push_back(e);
    endtask

    task automatic set_ops(input logic [31:0] b);
        for (int i = 0; i < NUM_REQ; i++) req_a[i*32 +: 32] = b | 32'(i);
        req_b = '0;
        req_c = '0;
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sbq.delete();
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        req_valid = '0;
        res_ready = 1'b1;
        while ((sbq.size() != 0 || res_valid) && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (sbq.size() != 0 || res_valid) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
        end
        res_ready = 1'b0;
    endtask

    // Result scoreboard: every pop must match the next expected {data, id}
    always @(negedge clk) begin : monitor
        fma_res_t e;
        if (!rst && res_valid && res_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result actual=%h/%0d required=none", res_data, res_id);
            end else begin
                e = sbq.pop_front();
                if (res_data !== e.data || res_id !== e.id[1:0]) begin
                    errors++;
                    $display("FAIL result_order actual=%h/%0d required=%h/%0d", res_data, res_id, e.data, e.id);
                end
            end
        end
    end

    // Credit scheme must make a write into a full FIFO impossible
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(dut.wr_en && dut.count == 4'(FIFO_DEPTH))) else begin
                errors++;
                $display("FAIL fifo_overflow count=%0d", dut.count);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b1111, 4'b0010};
        tbl[6]  = '{4'b0000, 4'b0000};
        tbl[7]  = '{4'b0011, 4'b0001};
        tbl[8]  = '{4'b1001, 4'b1000};
        tbl[9]  = '{4'b1010, 4'b0010};
        tbl[10] = '{4'b0100, 4'b0100};
        tbl[11] = '{4'b0001, 4'b0001};
        tbl[12] = '{4'b0001, 4'b0001};

        rst = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        tick();
        tick();
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_fma_in_valid", 32'(fma_in_valid), 0);
        chk("reset_fma_a", fma_a, 0);
        chk("reset_res_valid", 32'(res_valid), 0);
        chk("reset_res_data", res_data, 0);
        chk("reset_res_id", 32'(res_id), 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // single op from requester 2: 2*3+1
        set_ops(32'h0);
        req_a[64 +: 32] = 32'h4000_0000;
        req_b[64 +: 32] = 32'h4040_0000;
        req_c[64 +: 32] = 32'h3F80_0000;
        req_valid = 4'b0100;
        #1 chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        push_exp(32'h40E0_0000, 2);
        req_valid = '0;
        chk("single_fma_in_valid", 32'(fma_in_valid), 1);
        chk("single_fma_a", fma_a, 32'h4000_0000);
        chk("single_fma_c", fma_c, 32'h3F80_0000);
        tick();
        chk("single_fma_in_valid_drop", 32'(fma_in_valid), 0);
        repeat (LAT - 1) tick();
        chk("single_res_valid_early", 32'(res_valid), 0);
        tick();
        chk("single_res_valid", 32'(res_valid), 1);
        chk("single_res_data", res_data, 32'h40E0_0000);
        chk("single_res_id", 32'(res_id), 2);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("single_popped", 32'(res_valid), 0);

        // round-robin table from a fresh pointer
        do_reset();
        res_ready = 1'b1;
        for (int v = 0; v < 13; v++) begin
            base = 32'hA000_0000 | (32'(v) << 4);
            req_valid = tbl[v].rv;
            set_ops(base);
            #1 chk($sformatf("rr_ready_%0d", v), 32'(req_ready), 32'(tbl[v].ready));
            if (tbl[v].ready != 0) push_exp(base | 32'(oh_idx(tbl[v].ready)), oh_idx(tbl[v].ready));
            tick();
        end
        drain(40);

        // backpressure: exactly FIFO_DEPTH accepts, then one pop lets one more in
        rr_ptr = 1;
        n_acc = 0;
        res_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            base = 32'hB000_0000 | (32'(c) << 4);
            set_ops(base);
            exp_rdy = (n_acc < FIFO_DEPTH) ? 4'(1 << rr_ptr) : 4'b0000;
            #1 chk($sformatf("bp_ready_%0d", c), 32'(req_ready), 32'(exp_rdy));
            if (exp_rdy != 0) begin
                push_exp(base | 32'(rr_ptr), rr_ptr);
                rr_ptr = (rr_ptr + 1) % NUM_REQ;
                n_acc++;
            end
            tick();
        end
        base = 32'hB100_0000;
        set_ops(base);
        res_ready = 1'b1;
        #1 chk("bp_pop_cycle_ready", 32'(req_ready), 0);
        tick();
        res_ready = 1'b0;
        #1 chk("bp_reissue_ready", 32'(req_ready), 32'(1 << rr_ptr));
        push_exp(base | 32'(rr_ptr), rr_ptr);
        tick();
        #1 chk("bp_reblocked", 32'(req_ready), 0);
        drain(60);

        // simultaneous write and pop hold the FIFO at 3 across the pointer wrap
        for (int e = 1; e <= 16; e++) begin
            base = 32'hC000_0000 | (32'(e) << 4);
            set_ops(base);
            req_valid = (e <= 8) ? 4'b0001 : 4'b0000;
            res_ready = (e >= 10);
            if (e <= 8) begin
                #1 chk("simul_ready", 32'(req_ready), 1);
                push_exp(base, 0);
            end
            tick();
            if (e >= 9 && e <= 14) chk($sformatf("simul_count_%0d", e), 32'(dut.count), 3);
        end
        drain(30);

        // reset with 4 in flight and 2 buffered discards everything
        res_ready = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            set_ops(32'hD000_0000 | (32'(e) << 4));
            req_valid = (e <= 6) ? 4'b0001 : 4'b0000;
            tick();
        end
        chk("mid_res_valid_before", 32'(res_valid), 1);
        rst = 1'b1;
        #1 chk("mid_res_valid_reset", 32'(res_valid), 0);
        chk("mid_res_data_reset", res_data, 0);
        tick();
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        repeat (LAT + 4) tick();
        chk("mid_no_late_results", 32'(res_valid), 0);
        base = 32'hE000_0000;
        set_ops(base);
        req_valid = 4'b1111;
        #1 chk("mid_ptr_reset", 32'(req_ready), 1);
        push_exp(base, 0);
        tick();
        drain(20);

`ifdef FMA_SCHED_STATS_EN
        // 10 accepts and 3 blocked cycles
        do_reset();
        req_valid = 4'b0001;
        for (int e = 1; e <= 11; e++) begin
            base = 32'hF000_0000 | (32'(e) << 4);
            set_ops(base);
            if (e <= 8) push_exp(base, 0);
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        tick();
        res_ready = 1'b0;
        req_valid = 4'b0001;
        for (int e = 12; e <= 13; e++) begin
            base = 32'hF000_0000 | (32'(e) << 4);
            set_ops(base);
            #1 chk("stats_refill_ready", 32'(req_ready), 1);
            push_exp(base, 0);
            tick();
        end
        req_valid = '0;
        tick();
        chk("stat_issued", stat_issued, 10);
        chk("stat_blocked", stat_blocked, 3);
        drain(40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
